// File: rtl/carregador_matriz_if.sv
// Stream-in / matrix-out bundle for the 5x5 matrix loader.
// Optional build macro: LOADER_SIZE_SEL_EN adds the 3-bit 'size' selector.
// master = producer/consumer side (environment), slave = loader side.
interface carregador_matriz_if #(
  parameter int unsigned DIM = 5,
  parameter int unsigned DW  = 8
);
  localparam int unsigned MatW = DIM * DIM * DW;
  localparam int unsigned CntW = $clog2(DIM * DIM + 1);

  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            abort;
  logic [MatW-1:0] matrix_A;
  logic            matrix_valid;
  logic            matrix_ready;
  logic [CntW-1:0] elem_count;
`ifdef LOADER_SIZE_SEL_EN
  logic [2:0]      size;

  modport master (
    output in_data, in_valid, abort, matrix_ready, size,
    input  in_ready, matrix_A, matrix_valid, elem_count
  );

  modport slave (
    input  in_data, in_valid, abort, matrix_ready, size,
    output in_ready, matrix_A, matrix_valid, elem_count
  );
`else
  modport master (
    output in_data, in_valid, abort, matrix_ready,
    input  in_ready, matrix_A, matrix_valid, elem_count
  );

  modport slave (
    input  in_data, in_valid, abort, matrix_ready,
    output in_ready, matrix_A, matrix_valid, elem_count
  );
`endif
endinterface

// File: rtl/carregador_matriz.sv
// Row-major loader for the DIM x DIM signed matrix datapath.
// Accepts one element per valid/ready handshake, assembles the flat matrix bus and
// holds it with matrix_valid until the consumer takes it.
// Optional build macro: LOADER_SIZE_SEL_EN (runtime matrix order 2..DIM via bus.size).
module carregador_matriz #(
  parameter int unsigned DIM = 5,
  parameter int unsigned DW  = 8
) (
  input logic               clk,
  input logic               rst,
  carregador_matriz_if.slave bus
);

  localparam int unsigned Cells = DIM * DIM;
  localparam int unsigned MatW  = Cells * DW;
  localparam int unsigned CntW  = $clog2(Cells + 1);
  localparam int unsigned IdxW  = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFull
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] row_q, row_d;
  logic [IdxW-1:0] col_q, col_d;
  logic [IdxW-1:0] last_q, last_d;  // n-1 of the matrix being loaded
  logic [MatW-1:0] mat_q, mat_d;
  logic            valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            in_ready;
  logic            accept;
  logic [IdxW-1:0] last_sel;
  logic [IdxW-1:0] last_cur;
  logic [CntW-1:0] cell_idx;

  // Handshake: ready depends on state only, so it never loops back from in_valid.
  always_comb begin
    in_ready = (state_q != StFull);
    accept   = bus.in_valid & in_ready;
  end

  // Matrix order selection; only the first accept of a matrix latches it.
  always_comb begin
`ifdef LOADER_SIZE_SEL_EN
    if ((bus.size >= 3'd2) && (32'(bus.size) <= DIM)) begin
      last_sel = IdxW'(bus.size - 3'd1);
    end else begin
      last_sel = IdxW'(DIM - 1);
    end
`else
    last_sel = IdxW'(DIM - 1);
`endif
    last_cur = (state_q == StIdle) ? last_sel : last_q;
    // Positions keep the full DIM x DIM layout even for smaller n.
    cell_idx = CntW'(row_q) * CntW'(DIM) + CntW'(col_q);
  end

  // Next-state: abort beats accept and release; counters move only on accept.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    mat_d   = mat_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (bus.abort) begin
      state_d = StIdle;
      row_d   = '0;
      col_d   = '0;
      mat_d   = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            // First element of a new matrix wipes anything left from the last one.
            if (state_q == StIdle) begin
              mat_d  = '0;
              last_d = last_sel;
            end
            for (int k = 0; k < int'(Cells); k++) begin
              if (cell_idx == CntW'(k)) begin
                mat_d[k*DW +: DW] = bus.in_data;
              end
            end
            cnt_d = cnt_q + CntW'(1);
            if (col_q == last_cur) begin
              col_d = '0;
              if (row_q == last_cur) begin
                row_d   = '0;
                state_d = StFull;
                valid_d = 1'b1;
              end else begin
                row_d   = row_q + IdxW'(1);
                state_d = StLoad;
              end
            end else begin
              col_d   = col_q + IdxW'(1);
              state_d = StLoad;
            end
          end
        end
        StFull: begin
          if (bus.matrix_ready) begin
            state_d = StIdle;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= IdxW'(DIM - 1);
      mat_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      mat_q   <= mat_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive the bundle outputs straight from registers.
  always_comb begin
    bus.in_ready     = in_ready;
    bus.matrix_A     = mat_q;
    bus.matrix_valid = valid_q;
    bus.elem_count   = cnt_q;
  end

endmodule

// File: tb/tb_carregador_matriz.sv
// Scoreboard bench for carregador_matriz: expected matrices are queued when a load
// is issued and a negedge monitor compares them when matrix_valid rises.
module tb_carregador_matriz;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carregador_matriz_if #(.DIM(5), .DW(8)) bus ();

  carregador_matriz #(.DIM(5), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [199:0] m;
    int           cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic finish_now(input string why);
    errors++;
    $display("FAIL %s", why);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Effective matrix order from the size selector.
  function automatic int eff_n(input int sz);
`ifdef LOADER_SIZE_SEL_EN
    return (sz >= 2 && sz <= 5) ? sz : 5;
`else
    return 5;
`endif
  endfunction

  // Reference: byte k of the stream lands at element (k/n, k%n) of a zeroed 5x5 grid.
  function automatic logic [199:0] model(input logic [7:0] b[25], input int n);
    logic [199:0] m = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        m[(i*5+j)*8 +: 8] = b[i*n+j];
    return m;
  endfunction

  // Monitor: pop and compare on each rising matrix_valid; ready must be low while held.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.matrix_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_matrix: got %0h expected none", bus.matrix_A);
        end else begin
          e = exp_q.pop_front();
          chk("matrix_A", bus.matrix_A, e.m);
          chk("elem_count_full", bus.elem_count, e.cnt);
        end
      end
      if (bus.matrix_valid) chk("in_ready_while_full", bus.in_ready, 0);
      prev_valid <= bus.matrix_valid;
    end
  end

  // Present one byte and hold it until it is taken; returns at posedge+1.
  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready) begin
      @(negedge clk);
      t++;
      if (t > 200) finish_now("in_ready_timeout");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a whole matrix (base<0 means random bytes); ends at the negedge after the
  // final accept, where matrix_valid must already be high.
  task automatic load_matrix(input int sz, input int base, input int gap_min,
                             input int gap_max, input bit first_sent,
                             input logic [7:0] first_val);
    logic [7:0] b[25];
    exp_t e;
    int n = eff_n(sz);
    for (int k = 0; k < 25; k++) b[k] = (base >= 0) ? 8'(base + k) : 8'($urandom);
    if (first_sent) b[0] = first_val;
    e.m   = model(b, n);
    e.cnt = n * n;
    exp_q.push_back(e);
`ifdef LOADER_SIZE_SEL_EN
    if (!first_sent) bus.size = 3'(sz);
`endif
    for (int k = first_sent ? 1 : 0; k < n * n; k++) begin
      send(b[k]);
`ifdef LOADER_SIZE_SEL_EN
      bus.size = 3'($urandom);
`endif
      if (k != n * n - 1) idle($urandom_range(gap_max, gap_min));
    end
    @(negedge clk);
    chk("valid_latency", bus.matrix_valid, 1);
  endtask

  // Random wait, one-cycle matrix_ready pulse, then check the released state.
  task automatic release_matrix(input int wait_max);
    idle(1 + $urandom_range(wait_max, 0));
    bus.matrix_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.matrix_ready = 1'b0;
    @(negedge clk);
    chk("rel_valid", bus.matrix_valid, 0);
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_count", bus.elem_count, 0);
    idle(1);
  endtask

  initial begin
    #500000;
    finish_now("global_timeout");
  end

  initial begin
    int v;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.abort        = 1'b0;
    bus.matrix_ready = 1'b0;
`ifdef LOADER_SIZE_SEL_EN
    bus.size         = 3'd5;
`endif
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_valid", bus.matrix_valid, 0);
    chk("rst_count", bus.elem_count, 0);
    chk("rst_matrix", bus.matrix_A, 0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Dense 1..25, consumer not ready
    load_matrix(5, 1, 0, 0, 1'b0, 8'h00);
    chk("t1_a00", bus.matrix_A[7:0], 8'd1);
    chk("t1_a10", bus.matrix_A[47:40], 8'd6);
    chk("t1_a44", bus.matrix_A[199:192], 8'd25);
    chk("t1_in_ready", bus.in_ready, 0);
    chk("t1_count", bus.elem_count, 25);
    idle(1);

    // 0x7F held valid through FULL and the release cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7F;
    idle(3);
    @(negedge clk);
    chk("t2_held_count", bus.elem_count, 25);
    chk("t2_held_a44", bus.matrix_A[199:192], 8'd25);
    idle(1);
    bus.matrix_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.matrix_ready = 1'b0;
    @(negedge clk);
    chk("t2_rel_valid", bus.matrix_valid, 0);
    chk("t2_rel_in_ready", bus.in_ready, 1);
    chk("t2_rel_count", bus.elem_count, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t2_7f_count", bus.elem_count, 1);
    idle(1);
    load_matrix(5, -1, 0, 2, 1'b1, 8'h7F);
    release_matrix(2);

    // 0x80..0x98 with in_valid toggling
    load_matrix(5, 'h80, 1, 1, 1'b0, 8'h00);
    chk("t3_a00", bus.matrix_A[7:0], 8'h80);
    v = $signed(bus.matrix_A[7:0]);
    chk("t3_a00_signed", v, -128);
    release_matrix(1);

    // Abort after 10 bytes; matrix_ready during LOAD is ignored
    for (int k = 0; k < 10; k++) begin
      send(8'($urandom));
      if (k == 4) begin
        bus.matrix_ready = 1'b1;
        idle(1);
        bus.matrix_ready = 1'b0;
        @(negedge clk);
        chk("t4_mr_ignored", bus.elem_count, 5);
        idle(1);
      end
    end
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    idle(1);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_abort_count", bus.elem_count, 0);
    chk("t4_abort_matrix", bus.matrix_A, 0);
    chk("t4_abort_in_ready", bus.in_ready, 1);
    idle(1);
    load_matrix(5, -1, 0, 0, 1'b0, 8'h00);
    release_matrix(3);

    // Abort wins over release while FULL
    load_matrix(5, -1, 0, 1, 1'b0, 8'h00);
    idle(1);
    bus.abort        = 1'b1;
    bus.matrix_ready = 1'b1;
    idle(1);
    bus.abort        = 1'b0;
    bus.matrix_ready = 1'b0;
    @(negedge clk);
    chk("abort_full_valid", bus.matrix_valid, 0);
    chk("abort_full_count", bus.elem_count, 0);
    chk("abort_full_matrix", bus.matrix_A, 0);
    idle(1);

    // Asynchronous reset mid-load
    for (int k = 0; k < 12; k++) send(8'($urandom));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_count", bus.elem_count, 0);
    chk("t5_matrix", bus.matrix_A, 0);
    chk("t5_valid", bus.matrix_valid, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready_after", bus.in_ready, 1);
    idle(1);

    // Random matrices, gaps and release delays
    for (int r = 0; r < 6; r++) begin
`ifdef LOADER_SIZE_SEL_EN
      load_matrix(int'($urandom_range(7, 0)), -1, 0, 2, 1'b0, 8'h00);
`else
      load_matrix(5, -1, 0, 2, 1'b0, 8'h00);
`endif
      release_matrix(3);
    end

`ifdef LOADER_SIZE_SEL_EN
    // Size 3 after a full-size matrix: no residue outside the 3x3 corner
    load_matrix(3, 'h81, 0, 0, 1'b0, 8'h00);
    chk("t6_a10", bus.matrix_A[47:40], 8'h84);
    chk("t6_a20", bus.matrix_A[87:80], 8'h87);
    chk("t6_count", bus.elem_count, 9);
    release_matrix(1);
    load_matrix(2, -1, 0, 1, 1'b0, 8'h00);
    release_matrix(1);
    load_matrix(1, -1, 0, 1, 1'b0, 8'h00);
    release_matrix(1);
    load_matrix(7, -1, 0, 1, 1'b0, 8'h00);
    release_matrix(1);
`endif

    idle(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
